seq_mag_comp: RTL and testbench
===============================

Name: seq_mag_comp

Overview:
- Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands.
- Compares MSB-first, DIGIT bits per clock, using a start/busy/done handshake.
- Produces registered equal/greater/less flags and supports signed or unsigned operands.
- Drop-in sequential replacement for cascaded combinational compare cells on wide datapaths where area matters more than latency.

Parameters:
- WIDTH, 8: operand width in bits; must be a multiple of DIGIT and at least 2.
- DIGIT, 1: bits compared per cycle; 1 to WIDTH.
- SIGNED, 0: 0 = unsigned compare; 1 = two's-complement compare.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse; E/G/L valid on this cycle.
- E  output  1  A == B.
- G  output  1  A > B.
- L  output  1  A < B.

Behaviour:
- Reset: clk and rst as named above. rst is asynchronous and active-high. Asserting rst at any time, including mid-compare, forces state IDLE and busy=done=E=G=L=0. Any in-flight compare is discarded without a done pulse.
- N = WIDTH/DIGIT. cnt is ceil(log2(N+1)) bits wide.
- State machine:
  - IDLE: on start=1, load shift regs SA<=A and SB<=B, cnt<=N-1, and go to RUN. When SIGNED=1, the MSB of both A and B is inverted on load, which maps two's complement onto an unsigned compare.
  - RUN: busy=1. Each cycle compares the top DIGIT bits of SA and SB.
    - If the flags are undecided and the digits differ, set decided, gt=(digitA>digitB), lt=~gt.
    - SA and SB then shift left by DIGIT.
    - If cnt==0, go to DONE; otherwise decrement cnt.
  - DONE: busy=0, done=1 for exactly this cycle.
    - E=~decided, G=gt, L=lt, all registered on entry to DONE.
    - Next state is IDLE, or RUN if start=1 this cycle (back-to-back accepted; new operands loaded).
- Output holding: E/G/L hold their last result until the next DONE or rst; they do not clear on start. Exactly one of E/G/L is 1 after the first completed compare.
- start while busy=1: ignored; operands are not resampled.
- Latency: start sampled at edge k; done is high in the cycle following edge k+N. Default (N=8): done after 9 edges. Throughput: one compare per N+1 cycles.
- First differing digit wins; later digits cannot change the decided flags.
- A/B may change freely after the start edge.

Optional Feature:
- Macro: SEQ_MAG_COMP_EARLY_EXIT_EN.
- Defined: in RUN, if the current digit differs, the next state is DONE immediately regardless of cnt. Latency becomes j+1 edges, where j is the 1-based index (MSB-first) of the first differing digit. Equal operands still take N+1 edges.
- Undefined: RUN always runs all N digits. Latency is fixed at N+1 edges.

Test Plan:
- WIDTH=8, DIGIT=1, SIGNED=0; A=0xA5, B=0xA5, start 1 cycle -> busy 8 cycles; done at 9th edge with E=1, G=0, L=0.
- A=0x80, B=0x7F: SIGNED=0 -> G=1, L=0; SIGNED=1 -> L=1, G=0. Also A=0xFF, B=0x01 with SIGNED=1 -> L=1.
- With SEQ_MAG_COMP_EARLY_EXIT_EN: A=0x80, B=0x00 -> done after 2 edges, G=1. Without the macro -> done after 9 edges, G=1. A=0x01, B=0x00 -> 9 edges in both builds.
- DIGIT=4, WIDTH=8; A=0x3C, B=0x3D -> done after 3 edges, L=1. Back-to-back start in the DONE cycle with A=0x10, B=0x01 -> next done 3 edges later, G=1.
- Start A=0x12, B=0x34; pulse rst on the 4th RUN cycle -> busy=done=E=G=L=0 immediately (async), no done pulse. A following start compares correctly.
- start held high through RUN with changing A/B -> ignored until DONE; the result reflects the operands sampled at the first start.

Source files
------------

// File: rtl/seq_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, start/busy/done handshake.
// Optional macro SEQ_MAG_COMP_EARLY_EXIT_EN: finish as soon as the first differing digit is seen.
module seq_mag_comp #(
    parameter int WIDTH  = 8,
    parameter int DIGIT  = 1,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             E,
    output logic             G,
    output logic             L
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    // Flipping both MSBs turns a two's-complement compare into an unsigned one.
    localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             gt_q, gt_d, lt_q, lt_d;
    logic             e_q, e_d, g_q, g_d, l_q, l_d;

    logic [DIGIT-1:0] dig_a, dig_b;
    logic             dig_diff, last, load;

    assign dig_a    = sa_q[WIDTH-1 -: DIGIT];
    assign dig_b    = sb_q[WIDTH-1 -: DIGIT];
    assign dig_diff = (dig_a != dig_b);

`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
    assign last = (cnt_q == '0) || dig_diff;
`else
    assign last = (cnt_q == '0);
`endif

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        e_d       = e_q;
        g_d       = g_q;
        l_d       = l_q;
        load      = 1'b0;

        case (state_q)
            IDLE: load = start;
            RUN: begin
                if (!decided_q && dig_diff) begin
                    decided_d = 1'b1;
                    gt_d      = (dig_a > dig_b);
                    lt_d      = !(dig_a > dig_b);
                end
                sa_d = sa_q << DIGIT;
                sb_d = sb_q << DIGIT;
                if (last) begin
                    state_d = DONE;
                    e_d     = !decided_d;
                    g_d     = gt_d;
                    l_d     = lt_d;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                load    = start;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d   = RUN;
            sa_d      = A ^ SIGN_FLIP;
            sb_d      = B ^ SIGN_FLIP;
            cnt_d     = CW'(N - 1);
            decided_d = 1'b0;
            gt_d      = 1'b0;
            lt_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            e_q       <= 1'b0;
            g_q       <= 1'b0;
            l_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            e_q       <= e_d;
            g_q       <= g_d;
            l_q       <= l_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign E    = e_q;
    assign G    = g_q;
    assign L    = l_q;
endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp: three instances (unsigned/1-bit, signed/1-bit, unsigned/4-bit digits)
// checked against an arithmetic reference model; honours SEQ_MAG_COMP_EARLY_EXIT_EN.
module tb_seq_mag_comp;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_in, b_in;
    logic [2:0] start_v, busy_v, done_v, e_v, g_v, l_v;

    int total  = 0;
    int passes = 0;

    always #5 clk = ~clk;

    seq_mag_comp #(.WIDTH(8), .DIGIT(1), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start_v[0]), .A(a_in), .B(b_in),
        .busy(busy_v[0]), .done(done_v[0]), .E(e_v[0]), .G(g_v[0]), .L(l_v[0]));
    seq_mag_comp #(.WIDTH(8), .DIGIT(1), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_v[1]), .A(a_in), .B(b_in),
        .busy(busy_v[1]), .done(done_v[1]), .E(e_v[1]), .G(g_v[1]), .L(l_v[1]));
    seq_mag_comp #(.WIDTH(8), .DIGIT(4), .SIGNED(0)) dut_d4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .A(a_in), .B(b_in),
        .busy(busy_v[2]), .done(done_v[2]), .E(e_v[2]), .G(g_v[2]), .L(l_v[2]));

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: arithmetic compare plus latency from the first differing digit.
    task automatic model(input int d, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int e, output int g, output int l);
        int dg, n, j, ai, bi, mask;
        dg = (d == 2) ? 4 : 1;
        n = 8 / dg;
        mask = (1 << dg) - 1;
        if (d == 1) begin
            ai = int'($signed(a));
            bi = int'($signed(b));
        end else begin
            ai = int'(a);
            bi = int'(b);
        end
        e = (ai == bi) ? 1 : 0;
        g = (ai > bi) ? 1 : 0;
        l = (ai < bi) ? 1 : 0;
        j = 0;
        for (int i = n - 1; i >= 0; i--)
            if (j == 0 && (((int'(a) >> (i * dg)) ^ (int'(b) >> (i * dg))) & mask) != 0)
                j = n - i;
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
        lat = (j == 0) ? n + 1 : j + 1;
`else
        lat = n + 1;
`endif
    endtask

    task automatic launch(input int d, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        a_in = a;
        b_in = b;
        start_v[d] = 1'b1;
    endtask

    // Consumes the start edge, scrambles A/B, counts edges to done and checks the result.
    task automatic wait_chk(input int d, input logic [7:0] a, input logic [7:0] b, input string tag);
        int lat, el, ee, eg, ell;
        model(d, a, b, el, ee, eg, ell);
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        lat = 1;
        while (!done_v[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, el);
        chk({tag, ".E"}, int'(e_v[d]), ee);
        chk({tag, ".G"}, int'(g_v[d]), eg);
        chk({tag, ".L"}, int'(l_v[d]), ell);
        chk({tag, ".busy"}, int'(busy_v[d]), 0);
    endtask

    task automatic cmp(input int d, input logic [7:0] a, input logic [7:0] b, input string tag);
        launch(d, a, b);
        wait_chk(d, a, b, tag);
    endtask

    initial begin
        int lat, seen, d;
        logic [7:0] ra, rb;
        rst = 1'b1;
        start_v = '0;
        a_in = '0;
        b_in = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst%0d.bdegl", i), int'({busy_v[i], done_v[i], e_v[i], g_v[i], l_v[i]}), 0);
        rst = 1'b0;

        cmp(0, 8'hA5, 8'hA5, "eq_a5");
        cmp(0, 8'h80, 8'h7F, "u_80_7f");
        cmp(1, 8'h80, 8'h7F, "s_80_7f");
        cmp(1, 8'hFF, 8'h01, "s_ff_01");
        cmp(0, 8'h80, 8'h00, "u_80_00");
        cmp(0, 8'h01, 8'h00, "u_01_00");
        cmp(1, 8'h01, 8'h00, "s_01_00");

        // DIGIT=4 with a back-to-back start issued in the DONE cycle
        cmp(2, 8'h3C, 8'h3D, "d4_3c_3d");
        a_in = 8'h10;
        b_in = 8'h01;
        start_v[2] = 1'b1;
        wait_chk(2, 8'h10, 8'h01, "d4_b2b");

        // Async reset on the 4th RUN cycle, with E/G/L holding a prior result
        cmp(0, 8'h00, 8'hFF, "pre_rst");
        launch(0, 8'h12, 8'h34);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.busy", int'(busy_v[0]), 0);
        chk("rst_mid.done", int'(done_v[0]), 0);
        chk("rst_mid.EGL", int'({e_v[0], g_v[0], l_v[0]}), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[0]) seen = 1;
        end
        chk("rst_mid.no_done", seen, 0);
        cmp(0, 8'h12, 8'h34, "post_rst");

        // start held through RUN with changing operands
        launch(0, 8'h01, 8'h00);
        @(posedge clk); #1;
        lat = 1;
        repeat (4) begin
            a_in = 8'h00;
            b_in = 8'hFF;
            @(posedge clk); #1;
            lat++;
            chk("hold.busy", int'(busy_v[0]), 1);
        end
        start_v[0] = 1'b0;
        while (!done_v[0] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hold.lat", lat, 9);
        chk("hold.G", int'(g_v[0]), 1);
        chk("hold.L", int'(l_v[0]), 0);
        @(posedge clk); #1;
        chk("hold.done_pulse", int'(done_v[0]), 0);
        chk("hold.G_kept", int'(g_v[0]), 1);
        launch(0, 8'h00, 8'h00);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        chk("start_keeps.G", int'(g_v[0]), 1);
        chk("start_keeps.E", int'(e_v[0]), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("eq00.E", int'(e_v[0]), 1);

        // Randomized compares on all three configurations
        for (int k = 0; k < 45; k++) begin
            d = int'($urandom_range(0, 2));
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (8'h01 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            cmp(d, ra, rb, $sformatf("rnd%0d_d%0d", k, d));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
